// File: rtl/dmem_responder.sv
// Data-memory responder for the core's dcache port.
// Word RAM plus MMIO window (tohost, cycle counter), optional wait states.
module dmem_responder #(
    parameter int          DEPTH       = 4096,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dcache_addr,
    input  logic [3:0]  dcache_we,
    input  logic        dcache_re,
    input  logic [31:0] dcache_din,
    output logic [31:0] dcache_dout,
    output logic        stall,
    output logic [31:0] csr_tohost,
    output logic        tohost_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int WI = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [3:0] WAIT_INIT = WI[3:0];

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic        commit;

    logic [31:0] dout_q;
    logic [31:0] tohost_q;
    logic        valid_q;
    logic [31:0] cyc_q;

    logic [31:0] ram_q [DEPTH];

    logic          req;
    logic          mmio_sel;
    logic [25:0]   off_word;
    logic          is_tohost;
    logic          is_cycle;
    logic [AW-1:0] ram_idx;
    logic          ram_wr;
    logic          rd_commit;
    logic          th_wr;
    logic [31:0]   rd_data;
    logic          unused_addr;

    assign req       = dcache_re | (|dcache_we);
    assign mmio_sel  = dcache_addr[31:28] == MMIO_BASE[31:28];
    assign off_word  = dcache_addr[27:2];
    assign is_tohost = mmio_sel && (off_word == 26'd0);
    assign is_cycle  = mmio_sel && (off_word == 26'd4);
    assign ram_idx   = dcache_addr[AW+1:2];
    assign ram_wr    = commit && !mmio_sel && (|dcache_we);
    assign rd_commit = commit && dcache_re;
    assign th_wr     = commit && is_tohost && (|dcache_we);

    assign unused_addr = ^dcache_addr[1:0];

    // Request sequencing: count down wait states, then commit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        commit = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State register for the wait-state sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Load data mux: MMIO registers or RAM word (pre-write value).
    always_comb begin
        rd_data = 32'd0;
        if (mmio_sel) begin
            if (is_tohost) begin
                rd_data = tohost_q;
            end else if (is_cycle) begin
                rd_data = cyc_q;
            end
        end else begin
            rd_data = ram_q[ram_idx];
        end
    end

    // RAM byte-lane writes; contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (dcache_we[i]) begin
                    ram_q[ram_idx][8*i +: 8] <= dcache_din[8*i +: 8];
                end
            end
        end
    end

    // Registered load data, tohost register and its strobe, cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q   <= 32'd0;
            tohost_q <= 32'd0;
            valid_q  <= 1'b0;
            cyc_q    <= 32'd0;
        end else begin
            cyc_q   <= cyc_q + 32'd1;
            valid_q <= th_wr;
            if (rd_commit) begin
                dout_q <= rd_data;
            end
            if (th_wr) begin
                tohost_q <= dcache_din;
            end
        end
    end

    assign dcache_dout  = dout_q;
    assign csr_tohost   = tohost_q;
    assign tohost_valid = valid_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: zero-wait and three-wait instances.
// Table vectors for RAM/MMIO, hand sequences for stalls, tohost and reset.
module tb_dmem_responder;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_re, a_stall, a_tv;
    logic [31:0] a_addr, a_din, a_dout, a_th;
    logic [3:0]  a_we;

    logic        b_rst, b_re, b_stall, b_tv;
    logic [31:0] b_addr, b_din, b_dout, b_th;
    logic [3:0]  b_we;

    dmem_responder #(.DEPTH(4096), .WAIT_CYCLES(0)) dut_a (
        .clk(clk), .reset(a_rst),
        .dcache_addr(a_addr), .dcache_we(a_we),
        .dcache_re(a_re), .dcache_din(a_din),
        .dcache_dout(a_dout), .stall(a_stall),
        .csr_tohost(a_th), .tohost_valid(a_tv)
    );

    dmem_responder #(.DEPTH(4096), .WAIT_CYCLES(3)) dut_b (
        .clk(clk), .reset(b_rst),
        .dcache_addr(b_addr), .dcache_we(b_we),
        .dcache_re(b_re), .dcache_din(b_din),
        .dcache_dout(b_dout), .stall(b_stall),
        .csr_tohost(b_th), .tohost_valid(b_tv)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic        re;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[15];

    task automatic a_step(input logic [31:0] addr, input logic [3:0] we,
                          input logic re, input logic [31:0] din);
        @(negedge clk);
        a_addr = addr; a_we = we; a_re = re; a_din = din;
        #1 check("a_stall", {31'd0, a_stall}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Presents a request to dut_b and holds it until the commit edge.
    task automatic b_req(input logic [31:0] addr, input logic [3:0] we,
                         input logic re, input logic [31:0] din,
                         output int stalls);
        bit done;
        stalls = 0;
        done = 0;
        @(negedge clk);
        b_addr = addr; b_we = we; b_re = re; b_din = din;
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            if (b_stall) begin
                stalls++;
                @(negedge clk);
            end else begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        if (!done) check("b_timeout", 32'd1, 32'd0);
        b_we = 4'd0; b_re = 1'b0;
    endtask

    logic [31:0] v1, v2;
    int          s1, s2;

    initial begin
        a_rst = 1; a_addr = 0; a_we = 0; a_re = 0; a_din = 0;
        b_rst = 1; b_addr = 0; b_we = 0; b_re = 0; b_din = 0;

        tbl[0]  = '{32'h0000_0100, 4'hF, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000};
        tbl[1]  = '{32'h0000_0100, 4'h0, 1'b1, 32'h0,         32'hDEAD_BEEF};
        tbl[2]  = '{32'h0000_0200, 4'hF, 1'b0, 32'h1122_3344, 32'hDEAD_BEEF};
        tbl[3]  = '{32'h0000_0200, 4'h4, 1'b0, 32'h00AA_0000, 32'hDEAD_BEEF};
        tbl[4]  = '{32'h0000_0200, 4'h0, 1'b1, 32'h0,         32'h11AA_3344};
        tbl[5]  = '{32'h0000_0203, 4'h0, 1'b1, 32'h0,         32'h11AA_3344};
        tbl[6]  = '{32'h0000_4000, 4'hF, 1'b0, 32'h5A5A_5A5A, 32'h11AA_3344};
        tbl[7]  = '{32'h0000_0000, 4'h0, 1'b1, 32'h0,         32'h5A5A_5A5A};
        tbl[8]  = '{32'h0000_0300, 4'hF, 1'b0, 32'hCAFE_F00D, 32'h5A5A_5A5A};
        tbl[9]  = '{32'h0000_0300, 4'hF, 1'b1, 32'h1234_5678, 32'hCAFE_F00D};
        tbl[10] = '{32'h0000_0300, 4'h0, 1'b1, 32'h0,         32'h1234_5678};
        tbl[11] = '{32'h8000_0100, 4'hF, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678};
        tbl[12] = '{32'h0000_0100, 4'h0, 1'b1, 32'h0,         32'hDEAD_BEEF};
        tbl[13] = '{32'h8000_0008, 4'hF, 1'b0, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
        tbl[14] = '{32'h8000_0008, 4'h0, 1'b1, 32'h0,         32'h0000_0000};

        repeat (2) @(posedge clk);
        #1;
        check("a_rst_dout", a_dout, 32'd0);
        check("a_rst_stall", {31'd0, a_stall}, 32'd0);
        check("a_rst_tohost", a_th, 32'd0);
        check("a_rst_tv", {31'd0, a_tv}, 32'd0);
        check("b_rst_dout", b_dout, 32'd0);
        check("b_rst_stall", {31'd0, b_stall}, 32'd0);
        @(negedge clk);
        a_rst = 0; b_rst = 0;

        for (int i = 0; i < 15; i++) begin
            a_step(tbl[i].addr, tbl[i].we, tbl[i].re, tbl[i].din);
            check($sformatf("vec%0d", i), a_dout, tbl[i].exp);
        end
        check("a_tohost_untouched", a_th, 32'd0);

        a_step(32'h0, 4'h0, 1'b0, 32'h0);
        check("a_tv_idle", {31'd0, a_tv}, 32'd0);
        a_step(32'h8000_0000, 4'b0001, 1'b0, 32'h0000_0001);
        check("a_tohost", a_th, 32'h0000_0001);
        check("a_tv_pulse", {31'd0, a_tv}, 32'd1);
        a_step(32'h0, 4'h0, 1'b0, 32'h0);
        check("a_tv_drop", {31'd0, a_tv}, 32'd0);
        a_step(32'h8000_0000, 4'h0, 1'b1, 32'h0);
        check("a_tohost_rd", a_dout, 32'h0000_0001);

        a_step(32'h8000_0010, 4'h0, 1'b1, 32'h0);
        v1 = a_dout;
        repeat (4) a_step(32'h0, 4'h0, 1'b0, 32'h0);
        a_step(32'h8000_0010, 4'h0, 1'b1, 32'h0);
        v2 = a_dout;
        check("a_cycle_delta", v2 - v1, 32'd5);

        b_req(32'h0000_0040, 4'hF, 1'b0, 32'h0BAD_F00D, s1);
        check("b_store_stalls", s1, 32'd3);

        @(negedge clk);
        b_addr = 32'h0000_0040; b_re = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 check($sformatf("b_stall_c%0d", k), {31'd0, b_stall},
                     (k < 3) ? 32'd1 : 32'd0);
            if (k < 3) @(negedge clk);
        end
        @(posedge clk);
        #1 check("b_load", b_dout, 32'h0BAD_F00D);
        b_re = 1'b0;

        b_req(32'h0000_0100, 4'hF, 1'b0, 32'h7777_8888, s1);
        b_req(32'h0000_0100, 4'h0, 1'b1, 32'h0, s1);
        check("b_b2b_dout1", b_dout, 32'h7777_8888);
        b_req(32'h0000_0040, 4'h0, 1'b1, 32'h0, s2);
        check("b_b2b_dout2", b_dout, 32'h0BAD_F00D);
        check("b_b2b_stalls", s1 + s2, 32'd6);

        @(negedge clk);
        b_addr = 32'h0000_0040; b_we = 4'hF; b_din = 32'hFFFF_FFFF;
        #1 check("b_mid_stall1", {31'd0, b_stall}, 32'd1);
        @(negedge clk);
        #1 check("b_mid_stall2", {31'd0, b_stall}, 32'd1);
        b_rst = 1;
        @(negedge clk);
        b_rst = 0; b_we = 4'h0;
        #1;
        check("b_rst_stall0", {31'd0, b_stall}, 32'd0);
        check("b_rst_dout0", b_dout, 32'd0);
        repeat (3) @(negedge clk);
        b_req(32'h0000_0040, 4'h0, 1'b1, 32'h0, s1);
        check("b_ram_kept", b_dout, 32'h0BAD_F00D);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
